// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares the single port of the 256x16 instruction RAM between
// the CPU fetch path and a byte-wide program loader. A load stalls fetch, packs
// byte pairs big-endian into 16-bit words and writes them from a base address.
// Optional build macro IM_CHECKSUM_EN adds o_ld_csum, a running 16-bit sum of
// the words written by the current/most recent load.
module im_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   output logic              o_cpu_stall,
   output logic              o_cpu_valid,
   output logic [DATA_W-1:0] o_cpu_inst,
   input  logic              i_ld_start,
   input  logic [ADDR_W-1:0] i_ld_base,
   input  logic [ADDR_W:0]   i_ld_len,
   input  logic              i_ld_byte_valid,
   input  logic [7:0]        i_ld_byte,
   output logic              o_ld_byte_ready,
   output logic              o_ld_busy,
   output logic              o_ld_done,
   output logic              o_ld_err,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
`ifdef IM_CHECKSUM_EN
   ,
   output logic [15:0]       o_ld_csum
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_HI,
      LOAD_LO,
      WRITE,
      DONE
   } state_t;

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_wdata;
   logic              r_valid;
   logic              r_err;

   logic              w_fetch;
   logic              w_loadStart;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [ADDR_W:0]   w_countNext;

   // A fetch is only served in IDLE and only when no load start competes for the port.
   assign w_fetch     = (r_state == IDLE) & i_cpu_req & ~i_ld_start;
   assign w_loadStart = (r_state == IDLE) & i_ld_start & (i_ld_len != '0);
   // Address arithmetic is deliberately truncated so a load wraps 255 -> 0.
   assign w_wrAddr    = r_base + r_count[ADDR_W-1:0];
   assign w_countNext = r_count + ONE;

   assign o_cpu_stall     = (r_state != IDLE) | i_ld_start;
   assign o_cpu_valid     = r_valid;
   assign o_cpu_inst      = i_mem_rdata;
   assign o_ld_byte_ready = (r_state == LOAD_HI) | (r_state == LOAD_LO);
   assign o_ld_busy       = (r_state != IDLE);
   assign o_ld_done       = (r_state == DONE);
   assign o_ld_err        = r_err;
   assign o_mem_en        = w_fetch | (r_state == WRITE);
   assign o_mem_we        = (r_state == WRITE);
   assign o_mem_addr      = (r_state == WRITE) ? w_wrAddr :
                            (w_fetch ? i_cpu_addr : '0);
   assign o_mem_wdata     = r_wdata;

   // Main controller: load sequencing, word assembly and the fetch-valid / error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_len   <= '0;
         r_count <= '0;
         r_wdata <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_fetch;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_ld_start) begin
                  if (i_ld_len != '0) begin
                     r_base  <= i_ld_base;
                     r_len   <= i_ld_len;
                     r_count <= '0;
                     r_state <= LOAD_HI;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            LOAD_HI: begin
               if (i_ld_byte_valid) begin
                  r_wdata[DATA_W-1:8] <= i_ld_byte;
                  r_state             <= LOAD_LO;
               end
            end
            LOAD_LO: begin
               if (i_ld_byte_valid) begin
                  r_wdata[7:0] <= i_ld_byte;
                  r_state      <= WRITE;
               end
            end
            WRITE: begin
               r_count <= w_countNext;
               r_state <= (w_countNext == r_len) ? DONE : LOAD_HI;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef IM_CHECKSUM_EN
   logic [15:0] r_csum;

   assign o_ld_csum = r_csum;

   // Running checksum: restarts with each accepted load, accumulates every written word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum <= '0;
      end else if (w_loadStart) begin
         r_csum <= '0;
      end else if (r_state == WRITE) begin
         r_csum <= r_csum + r_wdata[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb_im_port_arbiter: table-driven directed bench for im_port_arbiter with a
// behavioural synchronous RAM; build with IM_CHECKSUM_EN to also check o_ld_csum.
module tb_im_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpuReq;
   logic [7:0]  cpuAddr;
   logic        cpuStall;
   logic        cpuValid;
   logic [15:0] cpuInst;
   logic        ldStart;
   logic [7:0]  ldBase;
   logic [8:0]  ldLen;
   logic        ldByteValid;
   logic [7:0]  ldByte;
   logic        ldByteReady;
   logic        ldBusy;
   logic        ldDone;
   logic        ldErr;
   logic        memEn;
   logic        memWe;
   logic [7:0]  memAddr;
   logic [15:0] memWdata;
   logic [15:0] memRdata;
`ifdef IM_CHECKSUM_EN
   logic [15:0] ldCsum;
`endif

   logic [15:0] memModel [256];
   int          errors = 0;
   int          checks = 0;
   int          weCount = 0;

   typedef struct {
      logic        req;
      logic [7:0]  addr;
      logic        start;
      logic [7:0]  base;
      logic [8:0]  len;
      logic        bv;
      logic [7:0]  byt;
      logic        eStall;
      logic        eValid;
      logic [15:0] eInst;
      logic        eBusy;
      logic        eReady;
      logic        eEn;
      logic        eWe;
      logic [7:0]  eAddr;
      logic [15:0] eWdata;
      logic        eDone;
      logic        eErr;
      logic [15:0] eCsum;
   } vec_t;

   vec_t vecs[$];

   im_port_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .i_cpu_req       (cpuReq),
      .i_cpu_addr      (cpuAddr),
      .o_cpu_stall     (cpuStall),
      .o_cpu_valid     (cpuValid),
      .o_cpu_inst      (cpuInst),
      .i_ld_start      (ldStart),
      .i_ld_base       (ldBase),
      .i_ld_len        (ldLen),
      .i_ld_byte_valid (ldByteValid),
      .i_ld_byte       (ldByte),
      .o_ld_byte_ready (ldByteReady),
      .o_ld_busy       (ldBusy),
      .o_ld_done       (ldDone),
      .o_ld_err        (ldErr),
      .o_mem_en        (memEn),
      .o_mem_we        (memWe),
      .o_mem_addr      (memAddr),
      .o_mem_wdata     (memWdata),
      .i_mem_rdata     (memRdata)
`ifdef IM_CHECKSUM_EN
      ,
      .o_ld_csum       (ldCsum)
`endif
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Behavioural 256x16 RAM with one-cycle synchronous read.
   always @(posedge clk) begin
      if (memEn) begin
         if (memWe) memModel[memAddr] <= memWdata;
         else       memRdata <= memModel[memAddr];
      end
   end

   // Counts every write strobe the RAM actually sees.
   always @(posedge clk) begin
      if (memWe && !rst) weCount++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic driveIn(input logic req, input logic [7:0] addr, input logic start,
                          input logic [7:0] base, input logic [8:0] len,
                          input logic bv, input logic [7:0] byt);
      cpuReq      = req;
      cpuAddr     = addr;
      ldStart     = start;
      ldBase      = base;
      ldLen       = len;
      ldByteValid = bv;
      ldByte      = byt;
   endtask

   task automatic applyStimulus(input vec_t v);
      driveIn(v.req, v.addr, v.start, v.base, v.len, v.bv, v.byt);
   endtask

   task automatic addRow(input logic req, input logic [7:0] addr, input logic start,
                         input logic [7:0] base, input logic [8:0] len,
                         input logic bv, input logic [7:0] byt,
                         input logic eStall, input logic eValid, input logic [15:0] eInst,
                         input logic eBusy, input logic eReady, input logic eEn,
                         input logic eWe, input logic [7:0] eAddr, input logic [15:0] eWdata,
                         input logic eDone, input logic eErr, input logic [15:0] eCsum);
      vec_t v;
      v.req = req; v.addr = addr; v.start = start; v.base = base; v.len = len;
      v.bv = bv; v.byt = byt; v.eStall = eStall; v.eValid = eValid; v.eInst = eInst;
      v.eBusy = eBusy; v.eReady = eReady; v.eEn = eEn; v.eWe = eWe; v.eAddr = eAddr;
      v.eWdata = eWdata; v.eDone = eDone; v.eErr = eErr; v.eCsum = eCsum;
      vecs.push_back(v);
   endtask

   task automatic checkRow(input int i, input vec_t v);
      checkOutput($sformatf("row%0d.stall", i), 32'(cpuStall), 32'(v.eStall));
      checkOutput($sformatf("row%0d.valid", i), 32'(cpuValid), 32'(v.eValid));
      if (v.eValid) checkOutput($sformatf("row%0d.inst", i), 32'(cpuInst), 32'(v.eInst));
      checkOutput($sformatf("row%0d.busy", i), 32'(ldBusy), 32'(v.eBusy));
      checkOutput($sformatf("row%0d.ready", i), 32'(ldByteReady), 32'(v.eReady));
      checkOutput($sformatf("row%0d.memEn", i), 32'(memEn), 32'(v.eEn));
      checkOutput($sformatf("row%0d.memWe", i), 32'(memWe), 32'(v.eWe));
      checkOutput($sformatf("row%0d.memAddr", i), 32'(memAddr), 32'(v.eAddr));
      if (v.eWe) checkOutput($sformatf("row%0d.wdata", i), 32'(memWdata), 32'(v.eWdata));
      checkOutput($sformatf("row%0d.done", i), 32'(ldDone), 32'(v.eDone));
      checkOutput($sformatf("row%0d.err", i), 32'(ldErr), 32'(v.eErr));
`ifdef IM_CHECKSUM_EN
      if (v.eDone) checkOutput($sformatf("row%0d.csum", i), 32'(ldCsum), 32'(v.eCsum));
`endif
   endtask

   initial begin
      int weBefore;
      for (int a = 0; a < 256; a++) memModel[a] = 16'h0000;
      memModel[8'h00] = 16'h3902;
      memModel[8'h01] = 16'h3B03;
      memModel[8'h02] = 16'h3C04;
      memModel[8'h30] = 16'h1234;
      memRdata = 16'h0000;

      // req addr st base len bv byte | stall valid inst busy rdy en we maddr wdata done err csum
      addRow(1,8'h00,0,8'h00,9'd0,0,8'h00, 0,0,16'h0000,0,0,1,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h01,0,8'h00,9'd0,0,8'h00, 0,1,16'h3902,0,0,1,0,8'h01,16'h0000,0,0,16'h0000);
      addRow(1,8'h02,0,8'h00,9'd0,0,8'h00, 0,1,16'h3B03,0,0,1,0,8'h02,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,0,8'h00, 0,1,16'h3C04,0,0,1,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,1,8'h10,9'd2,0,8'h00, 1,1,16'h3902,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,1,8'h39, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,1,8'h02, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,1,8'h3B, 1,0,16'h0000,1,0,1,1,8'h10,16'h3902,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,1,8'h3B, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,1,8'h03, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 1,0,16'h0000,1,0,1,1,8'h11,16'h3B03,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 1,0,16'h0000,1,0,0,0,8'h00,16'h0000,1,0,16'h7405);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 0,0,16'h0000,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h10,0,8'h00,9'd0,0,8'h00, 0,0,16'h0000,0,0,1,0,8'h10,16'h0000,0,0,16'h0000);
      addRow(1,8'h11,0,8'h00,9'd0,0,8'h00, 0,1,16'h3902,0,0,1,0,8'h11,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 0,1,16'h3B03,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,1,8'h20,9'd0,0,8'h00, 1,0,16'h0000,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 0,0,16'h0000,0,0,0,0,8'h00,16'h0000,0,1,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 0,0,16'h0000,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,1,8'hFF,9'd2,0,8'h00, 1,0,16'h0000,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,1,8'hAA, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,1,8'hBB, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,0,8'h00, 1,0,16'h0000,1,0,1,1,8'hFF,16'hAABB,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,1,8'hCC, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,1,8'hDD, 1,0,16'h0000,1,1,0,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,0,8'h00, 1,0,16'h0000,1,0,1,1,8'h00,16'hCCDD,0,0,16'h0000);
      addRow(1,8'h00,0,8'h00,9'd0,0,8'h00, 1,0,16'h0000,1,0,0,0,8'h00,16'h0000,1,0,16'h7798);
      addRow(1,8'h00,0,8'h00,9'd0,0,8'h00, 0,0,16'h0000,0,0,1,0,8'h00,16'h0000,0,0,16'h0000);
      addRow(1,8'hFF,0,8'h00,9'd0,0,8'h00, 0,1,16'hCCDD,0,0,1,0,8'hFF,16'h0000,0,0,16'h0000);
      addRow(0,8'h00,0,8'h00,9'd0,0,8'h00, 0,1,16'hAABB,0,0,0,0,8'h00,16'h0000,0,0,16'h0000);

      rst = 1'b1;
      driveIn(0, 8'h00, 0, 8'h00, 9'd0, 0, 8'h00);
      #3;
      checkOutput("reset.stall", 32'(cpuStall), 32'h0);
      checkOutput("reset.valid", 32'(cpuValid), 32'h0);
      checkOutput("reset.busy", 32'(ldBusy), 32'h0);
      checkOutput("reset.ready", 32'(ldByteReady), 32'h0);
      checkOutput("reset.done", 32'(ldDone), 32'h0);
      checkOutput("reset.err", 32'(ldErr), 32'h0);
      checkOutput("reset.memEn", 32'(memEn), 32'h0);
      checkOutput("reset.memWe", 32'(memWe), 32'h0);
      checkOutput("reset.memAddr", 32'(memAddr), 32'h0);
      checkOutput("reset.wdata", 32'(memWdata), 32'h0);
      #10;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #2;
         checkRow(i, vecs[i]);
      end

      // Reset in the middle of a word: the half-built word must never reach memory.
      weBefore = weCount;
      @(negedge clk);
      driveIn(0, 8'h00, 1, 8'h30, 9'd1, 0, 8'h00);
      @(negedge clk);
      driveIn(0, 8'h00, 0, 8'h00, 9'd0, 1, 8'h55);
      @(negedge clk);
      driveIn(0, 8'h00, 0, 8'h00, 9'd0, 1, 8'h66);
      #2;
      checkOutput("abort.busyBefore", 32'(ldBusy), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(ldBusy), 32'h0);
      checkOutput("abort.ready", 32'(ldByteReady), 32'h0);
      checkOutput("abort.stall", 32'(cpuStall), 32'h0);
      checkOutput("abort.memEn", 32'(memEn), 32'h0);
      checkOutput("abort.memWe", 32'(memWe), 32'h0);
      checkOutput("abort.wdata", 32'(memWdata), 32'h0);
      checkOutput("abort.done", 32'(ldDone), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      driveIn(0, 8'h00, 0, 8'h00, 9'd0, 0, 8'h00);
      @(negedge clk);
      driveIn(1, 8'h30, 0, 8'h00, 9'd0, 0, 8'h00);
      #2;
      checkOutput("abort.fetchEn", 32'(memEn), 32'h1);
      checkOutput("abort.fetchAddr", 32'(memAddr), 32'h30);
      @(negedge clk);
      driveIn(0, 8'h00, 0, 8'h00, 9'd0, 0, 8'h00);
      #2;
      checkOutput("abort.fetchValid", 32'(cpuValid), 32'h1);
      checkOutput("abort.fetchInst", 32'(cpuInst), 32'h1234);
      checkOutput("abort.noWrite", 32'(weCount - weBefore), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
